// File: rtl/rv32i_types.sv
// Shared types for the branch resolve path.
//   rv32i_word         : 32-bit machine word
//   rv32i_control_word : decoded control bits consumed at EX (branch, jump)
//   bp_record_t        : per-instruction prediction record queued at fetch
//   BP_GHR_W           : default global history width carried in bp_record_t
package rv32i_types;

    localparam int unsigned BP_GHR_W = 8;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        logic branch;
        logic jump;
    } rv32i_control_word;

    typedef struct packed {
        rv32i_word             pc;
        logic                  local_pred;
        logic                  global_pred;
        logic                  final_pred;
        rv32i_word             pred_target;
        logic [BP_GHR_W-1:0]   ghr;
    } bp_record_t;

endpackage

// File: rtl/bp_record_fifo.sv
// In-order queue of prediction records.
//   clk, rst_n : clock, synchronous active-low reset (drops all records)
//   push/wdata : enqueue at tail; accepted when not full, or when full with a same-cycle pop
//   pop/rdata  : dequeue head; rdata always shows the head record
//   clear      : discard every record (overrides push and pop)
//   full/empty : occupancy flags from the registered count
module bp_record_fifo
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  bp_record_t wdata,
    input  logic       pop,
    input  logic       clear,
    output bp_record_t rdata,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    bp_record_t       mem_q [DEPTH];
    bp_record_t       mem_d [DEPTH];
    logic             wr_en, rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[head_q];

    // A full queue still takes a push when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop) & ~clear;
    assign rd_en = pop & ~empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en) begin
                mem_d[tail_q] = wdata;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (rd_en) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: pairs the oldest fetch-time prediction with the EX
// outcome, drives predictor/chooser updates and raises redirect on mispredict.
//   if_*      : prediction record pushed by fetch; if_ready = queue not full
//   ex_*      : resolution of the oldest control-flow instruction
//   redirect* : one-cycle flush pulse, correct next PC, repaired GHR
//   upd_*     : one-cycle table update strobe and payload
//   underflow_err : sticky, ex_valid seen with an empty queue
// Optional: define BRU_PERF_CNT_EN to add saturating perf_resolved/perf_mispred.
module branch_resolve_unit
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GHR_W = rv32i_types::BP_GHR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_push,
    output logic              if_ready,
    input  logic [31:0]       if_pc,
    input  logic              if_local_pred,
    input  logic              if_global_pred,
    input  logic              if_final_pred,
    input  logic [31:0]       if_pred_target,
    input  logic [GHR_W-1:0]  if_ghr,
    input  logic              ex_valid,
    input  rv32i_control_word ex_controlw,
    input  logic              ex_br_en,
    input  logic [31:0]       ex_target,
    input  logic [31:0]       ex_pc_plus4,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic [GHR_W-1:0]  ghr_restore,
    output logic              upd_valid,
    output logic [31:0]       upd_pc,
    output logic              upd_taken,
    output logic              upd_local_ok,
    output logic              upd_global_ok,
    output logic              underflow_err
`ifdef BRU_PERF_CNT_EN
   ,output logic [31:0]       perf_resolved,
    output logic [31:0]       perf_mispred
`endif
);

    bp_record_t rec_in, head;
    logic       full, empty, resolve, taken, mispred;

    logic              redirect_q, redirect_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic [GHR_W-1:0]  ghr_restore_q, ghr_restore_d;
    logic              upd_valid_q, upd_valid_d;
    logic [31:0]       upd_pc_q, upd_pc_d;
    logic              upd_taken_q, upd_taken_d;
    logic              upd_local_ok_q, upd_local_ok_d;
    logic              upd_global_ok_q, upd_global_ok_d;
    logic              underflow_q, underflow_d;

    assign rec_in = '{pc: if_pc, local_pred: if_local_pred, global_pred: if_global_pred,
                      final_pred: if_final_pred, pred_target: if_pred_target, ghr: if_ghr};

    // Clearing on the mispredict pop also drops any same-cycle push (wrong path).
    bp_record_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (if_push),
        .wdata (rec_in),
        .pop   (resolve),
        .clear (resolve & mispred),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign if_ready = ~full;
    assign resolve  = ex_valid & ~empty;
    assign taken    = (ex_controlw.branch & ex_br_en) | ex_controlw.jump;
    assign mispred  = (head.final_pred != taken) |
                      (taken & head.final_pred & (head.pred_target != ex_target));

    always_comb begin
        redirect_d      = 1'b0;
        redirect_pc_d   = '0;
        ghr_restore_d   = '0;
        upd_valid_d     = 1'b0;
        upd_pc_d        = '0;
        upd_taken_d     = 1'b0;
        upd_local_ok_d  = 1'b0;
        upd_global_ok_d = 1'b0;
        underflow_d     = underflow_q | (ex_valid & empty);
        if (resolve) begin
            upd_valid_d     = 1'b1;
            upd_pc_d        = head.pc;
            upd_taken_d     = taken;
            upd_local_ok_d  = (head.local_pred == taken);
            upd_global_ok_d = (head.global_pred == taken);
            if (mispred) begin
                redirect_d    = 1'b1;
                redirect_pc_d = taken ? ex_target : ex_pc_plus4;
                ghr_restore_d = {head.ghr[GHR_W-2:0], taken};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_q      <= 1'b0;
            redirect_pc_q   <= '0;
            ghr_restore_q   <= '0;
            upd_valid_q     <= 1'b0;
            upd_pc_q        <= '0;
            upd_taken_q     <= 1'b0;
            upd_local_ok_q  <= 1'b0;
            upd_global_ok_q <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            redirect_q      <= redirect_d;
            redirect_pc_q   <= redirect_pc_d;
            ghr_restore_q   <= ghr_restore_d;
            upd_valid_q     <= upd_valid_d;
            upd_pc_q        <= upd_pc_d;
            upd_taken_q     <= upd_taken_d;
            upd_local_ok_q  <= upd_local_ok_d;
            upd_global_ok_q <= upd_global_ok_d;
            underflow_q     <= underflow_d;
        end
    end

    assign redirect      = redirect_q;
    assign redirect_pc   = redirect_pc_q;
    assign ghr_restore   = ghr_restore_q;
    assign upd_valid     = upd_valid_q;
    assign upd_pc        = upd_pc_q;
    assign upd_taken     = upd_taken_q;
    assign upd_local_ok  = upd_local_ok_q;
    assign upd_global_ok = upd_global_ok_q;
    assign underflow_err = underflow_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_resolved_q, perf_resolved_d;
    logic [31:0] perf_mispred_q, perf_mispred_d;

    always_comb begin
        perf_resolved_d = perf_resolved_q;
        perf_mispred_d  = perf_mispred_q;
        if (resolve && perf_resolved_q != '1) begin
            perf_resolved_d = perf_resolved_q + 32'd1;
        end
        if (resolve && mispred && perf_mispred_q != '1) begin
            perf_mispred_d = perf_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_resolved_q <= '0;
            perf_mispred_q  <= '0;
        end else begin
            perf_resolved_q <= perf_resolved_d;
            perf_mispred_q  <= perf_mispred_d;
        end
    end

    assign perf_resolved = perf_resolved_q;
    assign perf_mispred  = perf_mispred_q;
`endif

endmodule
